// File: rtl/imm_encoder_if.sv
// imm_encoder_if: request and output streams of the immediate encoder.
//   req_valid/req_ready : request handshake carrying req_op, req_value, req_tmpl
//   out_valid/out_ready : output handshake carrying out_inst, out_last, out_err
// master = request producer / output consumer, slave = encoder.
interface imm_encoder_if;
    localparam int unsigned OP_W   = 3;
    localparam int unsigned WORD_W = 32;

    logic              req_valid;
    logic              req_ready;
    logic [OP_W-1:0]   req_op;
    logic [WORD_W-1:0] req_value;
    logic [WORD_W-1:0] req_tmpl;

    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_inst;
    logic              out_last;
    logic              out_err;

    modport master (
        output req_valid, req_op, req_value, req_tmpl, out_ready,
        input  req_ready, out_valid, out_inst, out_last, out_err
    );

    modport slave (
        input  req_valid, req_op, req_value, req_tmpl, out_ready,
        output req_ready, out_valid, out_inst, out_last, out_err
    );
endinterface

// File: rtl/imm_encoder.sv
// imm_encoder: range-checks a value against an immediate format and ORs the
// field bits into an instruction template; also expands load-immediate
// requests into addi.w / lu12i.w / lu12i.w+ori words.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : imm_encoder_if.slave (request stream in, instruction stream out)
//   err_cnt  : saturating count of rejected requests
module imm_encoder #(
    parameter int unsigned ERR_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    imm_encoder_if.slave        bus,
    output logic [ERR_W-1:0]    err_cnt
);
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned RD_W    = 5;
    localparam int unsigned IMM12_W = 12;

    localparam logic [2:0] OP_UI5    = 3'b000;
    localparam logic [2:0] OP_SI12   = 3'b001;
    localparam logic [2:0] OP_UI12   = 3'b010;
    localparam logic [2:0] OP_SI20   = 3'b011;
    localparam logic [2:0] OP_OFFS16 = 3'b100;
    localparam logic [2:0] OP_OFFS26 = 3'b101;
    localparam logic [2:0] OP_LI     = 3'b110;

    localparam logic [WORD_W-1:0] ADDI_W_BASE  = 32'h0280_0000;
    localparam logic [WORD_W-1:0] LU12I_W_BASE = 32'h1400_0000;
    localparam logic [WORD_W-1:0] ORI_BASE     = 32'h0380_0000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EMIT    = 2'd1,
        EMIT_HI = 2'd2
    } state_t;

    state_t               state;
    logic                 out_valid_q;
    logic [WORD_W-1:0]    out_inst_q;
    logic                 out_last_q;
    logic                 out_err_q;
    logic [RD_W-1:0]      hi_rd_q;
    logic [IMM12_W-1:0]   hi_imm_q;

    logic [WORD_W-1:0]    v;
    logic [WORD_W-1:0]    t;
    logic [RD_W-1:0]      rd;
    logic                 fits_si12;
    logic                 fits_offs16;
    logic                 fits_offs26;
    logic                 lo_zero;
    logic                 aligned;
    logic [WORD_W-1:0]    li_addi;
    logic [WORD_W-1:0]    li_lu12i;
    logic [WORD_W-1:0]    ori_word;
    logic [WORD_W-1:0]    enc_inst;
    logic                 enc_err;
    logic                 enc_two;
    logic                 accept;

    assign v  = bus.req_value;
    assign t  = bus.req_tmpl;
    assign rd = bus.req_tmpl[RD_W-1:0];

    // Sign-range tests: every bit above the field's sign bit equals it.
    assign fits_si12   = (&v[31:11]) | ~(|v[31:11]);
    assign fits_offs16 = (&v[31:17]) | ~(|v[31:17]);
    assign fits_offs26 = (&v[31:27]) | ~(|v[31:27]);
    assign lo_zero     = (v[11:0] == 12'd0);
    assign aligned     = (v[1:0] == 2'b00);

    assign li_addi  = ADDI_W_BASE  | {10'd0, v[11:0], 5'd0, rd};
    assign li_lu12i = LU12I_W_BASE | {7'd0, v[31:12], rd};
    // Second LI word comes only from state captured at accept.
    assign ori_word = ORI_BASE | {10'd0, hi_imm_q, hi_rd_q, hi_rd_q};

    // Encode the request currently on the bus; illegal values pass the template through.
    always_comb begin
        enc_inst = t;
        enc_err  = 1'b0;
        enc_two  = 1'b0;
        case (bus.req_op)
            OP_UI5: begin
                if (v[31:5] == 27'd0) enc_inst = t | {17'd0, v[4:0], 10'd0};
                else                  enc_err  = 1'b1;
            end
            OP_SI12: begin
                if (fits_si12) enc_inst = t | {10'd0, v[11:0], 10'd0};
                else           enc_err  = 1'b1;
            end
            OP_UI12: begin
                if (v[31:12] == 20'd0) enc_inst = t | {10'd0, v[11:0], 10'd0};
                else                   enc_err  = 1'b1;
            end
            OP_SI20: begin
                if (lo_zero) enc_inst = t | {7'd0, v[31:12], 5'd0};
                else         enc_err  = 1'b1;
            end
            OP_OFFS16: begin
                if (aligned && fits_offs16) enc_inst = t | {6'd0, v[17:2], 10'd0};
                else                        enc_err  = 1'b1;
            end
            OP_OFFS26: begin
                if (aligned && fits_offs26) enc_inst = t | {6'd0, v[17:2], v[27:18]};
                else                        enc_err  = 1'b1;
            end
            OP_LI: begin
                if (fits_si12) begin
                    enc_inst = li_addi;
                end else if (lo_zero) begin
                    enc_inst = li_lu12i;
                end else begin
                    enc_inst = li_lu12i;
                    enc_two  = 1'b1;
                end
            end
            default: enc_err = 1'b1;
        endcase
    end

    // A new request may enter whenever no word is held or the held last word is leaving.
    assign bus.req_ready = (state == IDLE) || ((state == EMIT) && bus.out_ready);
    assign accept        = bus.req_valid && bus.req_ready;

    assign bus.out_valid = out_valid_q;
    assign bus.out_inst  = out_inst_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_err   = out_err_q;

    // Output FSM, output word register and error counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            out_inst_q  <= '0;
            out_last_q  <= 1'b0;
            out_err_q   <= 1'b0;
            hi_rd_q     <= '0;
            hi_imm_q    <= '0;
            err_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                end
                EMIT: begin
                    if (bus.out_ready && !bus.req_valid) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                EMIT_HI: begin
                    if (bus.out_ready) begin
                        state      <= EMIT;
                        out_inst_q <= ori_word;
                        out_last_q <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase

            // Accepting a request overrides the hold/idle decisions above.
            if (accept) begin
                state       <= enc_two ? EMIT_HI : EMIT;
                out_valid_q <= 1'b1;
                out_inst_q  <= enc_inst;
                out_last_q  <= !enc_two;
                out_err_q   <= enc_err;
                hi_rd_q     <= rd;
                hi_imm_q    <= v[11:0];
                if (enc_err && (err_cnt != {ERR_W{1'b1}})) begin
                    err_cnt <= err_cnt + ERR_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder: directed stimulus for imm_encoder with a queue-based
// reference model checked every cycle plus literal expectations.
module tb_imm_encoder;
    localparam int unsigned TB_ERR_W = 3;
    localparam int unsigned ERR_MAX  = 7;

    typedef struct packed {
        logic [31:0] inst;
        logic        last;
        logic        err;
    } word_t;

    logic clk;
    logic rst;
    logic [TB_ERR_W-1:0] err_cnt;
    int unsigned n_checks;
    int unsigned n_err;
    int unsigned cyc;
    int unsigned m_err;
    word_t q[$];

    imm_encoder_if bus();

    imm_encoder #(.ERR_W(TB_ERR_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .err_cnt (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void push(input logic [31:0] i, input logic l, input logic e);
        word_t w;
        w.inst = i;
        w.last = l;
        w.err  = e;
        q.push_back(w);
    endfunction

    // Reference: arithmetic range checks and shifted field insertion.
    function automatic logic model_push(input logic [2:0] op, input logic [31:0] v, input logic [31:0] t);
        longint sv;
        logic [31:0] w;
        logic [31:0] rd;
        logic ok;
        sv = longint'($signed(v));
        rd = t % 32;
        ok = 1'b1;
        w  = t;
        case (op)
            3'd0: begin ok = (v < 32);                   w = t | (v << 10); end
            3'd1: begin ok = (sv >= -2048 && sv <= 2047); w = t | ((v % 4096) << 10); end
            3'd2: begin ok = (v < 4096);                 w = t | ((v % 4096) << 10); end
            3'd3: begin ok = (v % 4096 == 0);            w = t | ((v / 4096) << 5); end
            3'd4: begin
                ok = (v % 4 == 0) && sv >= -131072 && sv < 131072;
                w  = t | (((v / 4) % 65536) << 10);
            end
            3'd5: begin
                ok = (v % 4 == 0) && sv >= -134217728 && sv < 134217728;
                w  = t | (((v / 4) % 65536) << 10) | ((v / 262144) % 1024);
            end
            3'd6: begin
                if (sv >= -2048 && sv <= 2047) begin
                    push(32'h0280_0000 + ((v % 4096) << 10) + rd, 1'b1, 1'b0);
                end else if (v % 4096 == 0) begin
                    push(32'h1400_0000 + ((v / 4096) << 5) + rd, 1'b1, 1'b0);
                end else begin
                    push(32'h1400_0000 + ((v / 4096) << 5) + rd, 1'b0, 1'b0);
                    push(32'h0380_0000 + ((v % 4096) << 10) + rd * 32 + rd, 1'b1, 1'b0);
                end
                return 1'b0;
            end
            default: ok = 1'b0;
        endcase
        if (ok) push(w, 1'b1, 1'b0);
        else    push(t, 1'b1, 1'b1);
        return !ok;
    endfunction

    // Per-cycle comparison against the model, sampled on the falling edge.
    always @(negedge clk) begin
        logic exp_ready;
        if (rst) begin
            q.delete();
            m_err = 0;
            check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        end else begin
            exp_ready = (q.size() == 0) || (q.size() == 1 && bus.out_ready);
            check("mon_out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
            check("mon_req_ready", 32'(bus.req_ready), 32'(exp_ready));
            check("mon_err_cnt", 32'(err_cnt), 32'(m_err));
            if (q.size() != 0) begin
                check("mon_inst", bus.out_inst, q[0].inst);
                check("mon_last", 32'(bus.out_last), 32'(q[0].last));
                check("mon_err", 32'(bus.out_err), 32'(q[0].err));
            end
            if (bus.out_valid && bus.out_ready && q.size() != 0) void'(q.pop_front());
            if (bus.req_valid && bus.req_ready) begin
                if (model_push(bus.req_op, bus.req_value, bus.req_tmpl) && m_err < ERR_MAX)
                    m_err++;
            end
        end
    end

    // Present one request until accepted; returns 1 ns after the accepting edge.
    task automatic send(input logic [2:0] op, input logic [31:0] v, input logic [31:0] t);
        int n;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_value = v;
        bus.req_tmpl  = t;
        n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!bus.req_ready) begin
            n_checks++;
            n_err++;
            $display("FAIL send_timeout: req_ready=0 after %0d cycles, expected 1", n);
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] b2b_val [4];
    logic [31:0] b2b_exp [4];
    int unsigned c0;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected $finish");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_err    = 0;
        cyc      = 0;
        m_err    = 0;
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_op    = 3'd0;
        bus.req_value = 32'd0;
        bus.req_tmpl  = 32'd0;
        bus.out_ready = 1'b1;
        b2b_val = '{32'd0, 32'd1, 32'd17, 32'd31};
        b2b_exp = '{32'h0000_0003, 32'h0000_0403, 32'h0000_4403, 32'h0000_7C03};

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_out_inst", bus.out_inst, 32'd0);
        check("reset_out_last", 32'(bus.out_last), 32'd0);
        check("reset_out_err", 32'(bus.out_err), 32'd0);
        check("reset_err_cnt", 32'(err_cnt), 32'd0);
        check("reset_req_ready", 32'(bus.req_ready), 32'd1);

        // si12 legal and out-of-range
        send(3'b001, 32'hFFFF_F800, 32'h0280_0000);
        check("si12_inst", bus.out_inst, 32'h02A0_0000);
        check("si12_err", 32'(bus.out_err), 32'd0);
        check("si12_last", 32'(bus.out_last), 32'd1);
        send(3'b001, 32'h0000_0800, 32'h0280_0000);
        check("si12_bad_inst", bus.out_inst, 32'h0280_0000);
        check("si12_bad_err", 32'(bus.out_err), 32'd1);
        check("si12_bad_errcnt", 32'(err_cnt), 32'd1);

        // two-word load-immediate
        send(3'b110, 32'h1234_5678, 32'h0000_0005);
        check("li2_hi_inst", bus.out_inst, 32'h1424_68A5);
        check("li2_hi_last", 32'(bus.out_last), 32'd0);
        check("li2_hi_ready", 32'(bus.req_ready), 32'd0);
        step();
        check("li2_lo_inst", bus.out_inst, 32'h0399_E0A5);
        check("li2_lo_last", 32'(bus.out_last), 32'd1);

        // single-word load-immediates
        send(3'b110, 32'hFFFF_FFFF, 32'hFFFF_FFE1);
        check("li_addi_inst", bus.out_inst, 32'h02BF_FC01);
        check("li_addi_last", 32'(bus.out_last), 32'd1);
        send(3'b110, 32'hABCD_E000, 32'h0000_0001);
        check("li_lu12i_inst", bus.out_inst, 32'h1557_9BC1);
        check("li_lu12i_last", 32'(bus.out_last), 32'd1);

        // offs26
        send(3'b101, 32'h0000_0404, 32'h5000_0000);
        check("offs26_inst", bus.out_inst, 32'h5004_0400);
        check("offs26_err", 32'(bus.out_err), 32'd0);
        send(3'b101, 32'h0000_0402, 32'h5000_0000);
        check("offs26_bad_inst", bus.out_inst, 32'h5000_0000);
        check("offs26_bad_err", 32'(bus.out_err), 32'd1);

        // range boundaries of the remaining formats, checked by the model
        send(3'b000, 32'd31, 32'h0000_0000);
        send(3'b000, 32'd32, 32'h0000_0000);
        send(3'b001, 32'h0000_07FF, 32'h0000_0000);
        send(3'b010, 32'h0000_0FFF, 32'h0000_0000);
        send(3'b010, 32'h0000_1000, 32'h0000_0000);
        send(3'b011, 32'h1234_5000, 32'h0000_0000);
        send(3'b011, 32'h0000_1001, 32'h0000_0000);
        send(3'b100, 32'hFFFE_0000, 32'h4C00_0000);
        send(3'b100, 32'h0001_FFFC, 32'h4C00_0000);
        send(3'b100, 32'h0002_0000, 32'h4C00_0000);
        send(3'b100, 32'h0000_0006, 32'h4C00_0000);
        send(3'b101, 32'hF800_0000, 32'h5000_0000);
        send(3'b101, 32'h0800_0000, 32'h5000_0000);
        send(3'b111, 32'h0000_0000, 32'h1234_5678);
        send(3'b110, 32'hFFFF_F800, 32'h0000_001F);
        send(3'b110, 32'h0000_0800, 32'h0000_0002);
        step();
        step();

        // backpressure on a two-word load-immediate
        bus.out_ready = 1'b0;
        send(3'b110, 32'h1234_5678, 32'h0000_0005);
        repeat (3) begin
            step();
            check("bp_inst", bus.out_inst, 32'h1424_68A5);
            check("bp_last", 32'(bus.out_last), 32'd0);
            check("bp_valid", 32'(bus.out_valid), 32'd1);
            check("bp_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        step();
        check("bp_ori_inst", bus.out_inst, 32'h0399_E0A5);
        check("bp_ori_last", 32'(bus.out_last), 32'd1);
        step();
        check("bp_drained", 32'(bus.out_valid), 32'd0);

        // back-to-back single-word requests
        c0 = cyc;
        for (int i = 0; i < 4; i++) begin
            send(3'b000, b2b_val[i], 32'h0000_0003);
            check("b2b_inst", bus.out_inst, b2b_exp[i]);
        end
        check("b2b_cycles", cyc - c0, 32'd4);

        // error counter saturation
        send(3'b111, 32'd0, 32'hDEAD_BEEF);
        send(3'b111, 32'd1, 32'hDEAD_BEEF);
        check("err_sat", 32'(err_cnt), 32'd7);
        step();
        step();

        // reset while the ori word is pending
        bus.out_ready = 1'b0;
        send(3'b110, 32'h1234_5678, 32'h0000_0005);
        #2 rst = 1'b1;
        #1;
        check("midrst_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_ready", 32'(bus.req_ready), 32'd1);
        check("midrst_errcnt", 32'(err_cnt), 32'd0);
        step();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) begin
            step();
            check("postrst_valid", 32'(bus.out_valid), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
